// File: rtl/rx_buffer_ctrl.sv
// Receive buffer controller: circular word buffer write pointer with rollback,
// free-space accounting and a queue of committed packet descriptors.
`timescale 1ns/1ps
module rx_buffer_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int LEN_WIDTH     = 7,
  parameter int MAX_PKT_WORDS = 64,
  parameter int NUM_DESC      = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_start,
  input  logic                  wr_en,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  mem_wen,
  output logic                  overflow,
  output logic                  pkt_valid,
  output logic [ADDR_WIDTH-1:0] pkt_base,
  output logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  pkt_release,
  output logic [ADDR_WIDTH:0]   free_words,
  output logic [7:0]            drop_count
);

  localparam int QW = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
  localparam int CW = QW + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_PKT_WORDS);
  localparam logic [ADDR_WIDTH:0]  MAX_FREE = (ADDR_WIDTH+1)'(MAX_PKT_WORDS);
  localparam logic [ADDR_WIDTH:0]  ALL_FREE = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]        FULL_CNT = CW'(NUM_DESC);

  typedef enum logic [1:0] {S_IDLE, S_WRITING, S_DROP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  trunc_q, trunc_d;
  logic [ADDR_WIDTH:0]   free_q, free_d;
  logic [7:0]            drop_q, drop_d;
  logic [QW-1:0]         head_q, head_d;
  logic [QW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] desc_base_q [NUM_DESC];
  logic [ADDR_WIDTH-1:0] desc_base_d [NUM_DESC];
  logic [LEN_WIDTH-1:0]  desc_len_q  [NUM_DESC];
  logic [LEN_WIDTH-1:0]  desc_len_d  [NUM_DESC];

  logic                  accept;
  logic                  over_max;
  logic [LEN_WIDTH-1:0]  clen;
  logic [LEN_WIDTH-1:0]  rb_len;
  logic [LEN_WIDTH-1:0]  rel_len;
  logic                  push;
  logic                  pop;
  logic                  drop_inc;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    desc_base_d = desc_base_q;
    desc_len_d  = desc_len_q;
    push        = 1'b0;
    drop_inc    = 1'b0;
    rb_len      = '0;

    accept   = (state_q == S_WRITING) && wr_en && (len_q < MAX_LEN);
    over_max = (state_q == S_WRITING) && wr_en && (len_q >= MAX_LEN);
    // Length including this cycle's write, so a same-cycle word is committed or rolled back too.
    clen     = len_q + LEN_WIDTH'(accept);

    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          if (overflow) begin
            state_d  = S_DROP;
            drop_inc = 1'b1;
          end else begin
            state_d = S_WRITING;
            base_d  = wr_ptr_q;
            len_d   = '0;
            trunc_d = 1'b0;
          end
        end
      end
      S_WRITING: begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(accept);
        len_d    = clen;
        if (over_max) trunc_d = 1'b1;
        if (wr_abort) begin
          state_d  = S_IDLE;
          wr_ptr_d = base_q;
          rb_len   = clen;
          drop_inc = 1'b1;
        end else if (wr_commit) begin
          state_d = S_IDLE;
          if ((clen == '0) || trunc_q || over_max) begin
            wr_ptr_d = base_q;
            rb_len   = clen;
            drop_inc = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (wr_commit || wr_abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pop     = pkt_release && (count_q != '0);
    rel_len = pop ? desc_len_q[head_q] : '0;

    if (push) begin
      desc_base_d[tail_q] = base_q;
      desc_len_d[tail_q]  = clen;
    end
    head_d  = head_q + QW'(pop);
    tail_d  = tail_q + QW'(push);
    count_d = count_q + CW'(push) - CW'(pop);

    free_d = free_q - (ADDR_WIDTH+1)'(accept) + (ADDR_WIDTH+1)'(rel_len)
           + (ADDR_WIDTH+1)'(rb_len);
    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
      trunc_q  <= 1'b0;
      free_q   <= ALL_FREE;
      drop_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_DESC; i++) begin
        desc_base_q[i] <= '0;
        desc_len_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      trunc_q     <= trunc_d;
      free_q      <= free_d;
      drop_q      <= drop_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      desc_base_q <= desc_base_d;
      desc_len_q  <= desc_len_d;
    end
  end

  assign mem_wen    = accept;
  assign wr_addr    = wr_ptr_q;
  assign overflow   = (count_q == FULL_CNT) || (free_q < MAX_FREE);
  assign pkt_valid  = (count_q != '0);
  assign pkt_base   = pkt_valid ? desc_base_q[head_q] : '0;
  assign pkt_len    = pkt_valid ? desc_len_q[head_q] : '0;
  assign free_words = free_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl; committed descriptors are predicted into a
// queue when the commit is driven and checked when the consumer releases them.
`timescale 1ns/1ps
module tb_rx_buffer_ctrl;
  localparam int AW   = 8;
  localparam int LW   = 7;
  localparam int MAXW = 64;
  localparam int ND   = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          wr_start, wr_en, wr_commit, wr_abort, pkt_release;
  logic [AW-1:0] wr_addr;
  logic          mem_wen, overflow, pkt_valid;
  logic [AW-1:0] pkt_base;
  logic [LW-1:0] pkt_len;
  logic [AW:0]   free_words;
  logic [7:0]    drop_count;

  int checks   = 0;
  int failures = 0;
  logic [AW+LW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rx_buffer_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_PKT_WORDS(MAXW), .NUM_DESC(ND)) dut (
    .clk(clk), .n_rst(n_rst),
    .wr_start(wr_start), .wr_en(wr_en), .wr_commit(wr_commit), .wr_abort(wr_abort),
    .wr_addr(wr_addr), .mem_wen(mem_wen), .overflow(overflow),
    .pkt_valid(pkt_valid), .pkt_base(pkt_base), .pkt_len(pkt_len),
    .pkt_release(pkt_release), .free_words(free_words), .drop_count(drop_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic c, input logic a, input logic r);
    @(negedge clk);
    wr_start = s; wr_en = e; wr_commit = c; wr_abort = a; pkt_release = r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_beat(input int addr, input logic exp_wen);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mem_wen", mem_wen, exp_wen);
    if (exp_wen) chk("wr_addr", wr_addr, 32'(addr % 256));
  endtask

  task automatic send_pkt(input int n, input int first);
    logic [AW-1:0] b;
    logic [LW-1:0] l;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) write_beat(first + i, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    b = AW'(first % 256);
    l = LW'(n);
    exp_q.push_back({b, l});
  endtask

  task automatic check_head();
    logic [AW+LW-1:0] e;
    chk("pkt_valid_head", pkt_valid, 1'b1);
    e = exp_q.pop_front();
    chk("pkt_base_head", pkt_base, e[AW+LW-1:LW]);
    chk("pkt_len_head", pkt_len, e[LW-1:0]);
  endtask

  task automatic release_head();
    @(negedge clk);
    #1;
    check_head();
    wr_start = 0; wr_en = 0; wr_commit = 0; wr_abort = 0; pkt_release = 1;
  endtask

  initial begin
    n_rst = 1'b0;
    wr_start = 0; wr_en = 0; wr_commit = 0; wr_abort = 0; pkt_release = 0;
    idle();
    idle();
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_base", pkt_base, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_free", free_words, 256);
    chk("rst_drop", drop_count, 0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_overflow", overflow, 1'b0);
    n_rst = 1'b1;

    // basic 3-word packet
    send_pkt(3, 0);
    idle();
    chk("a_valid", pkt_valid, 1'b1);
    chk("a_base", pkt_base, 0);
    chk("a_len", pkt_len, 3);
    chk("a_free", free_words, 253);

    // aborted 5-word packet rolls back
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) write_beat(3 + i, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("abort_free", free_words, 253);
    chk("abort_drop", drop_count, 1);
    chk("abort_wr_addr", wr_addr, 3);

    // fill the descriptor queue
    send_pkt(1, 3);
    send_pkt(1, 4);
    send_pkt(1, 5);
    idle();
    chk("full_overflow", overflow, 1'b1);
    chk("full_free", free_words, 250);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    write_beat(6, 1'b0);
    write_beat(6, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("drop_count_drop", drop_count, 2);
    chk("drop_free", free_words, 250);
    chk("drop_wr_addr", wr_addr, 6);
    release_head();
    idle();
    chk("rel_overflow", overflow, 1'b0);
    chk("rel_free", free_words, 253);

    // drain and advance the pointer to 254
    release_head();
    release_head();
    release_head();
    idle();
    chk("drain_free", free_words, 256);
    chk("drain_valid", pkt_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_pkt(62, 6 + 62 * k);
      release_head();
    end
    idle();
    chk("pre_wrap_addr", wr_addr, 254);

    // wrap-around packet
    send_pkt(4, 254);
    idle();
    chk("wrap_base", pkt_base, 254);
    chk("wrap_len", pkt_len, 4);
    release_head();

    // commit + write + release in one cycle
    send_pkt(2, 2);
    idle();
    chk("f_free", free_words, 254);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    write_beat(4, 1'b1);
    @(negedge clk);
    #1;
    check_head();
    wr_start = 0; wr_en = 1; wr_commit = 1; wr_abort = 0; pkt_release = 1;
    #1;
    chk("simul_mem_wen", mem_wen, 1'b1);
    chk("simul_wr_addr", wr_addr, 5);
    exp_q.push_back({8'd4, 7'd2});
    idle();
    chk("simul_free", free_words, 254);
    chk("simul_valid", pkt_valid, 1'b1);
    chk("simul_overflow", overflow, 1'b0);
    release_head();
    idle();
    chk("simul_count", pkt_valid, 1'b0);
    chk("simul_free2", free_words, 256);

    // 65 beats: the last is suppressed and the packet is dropped
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) write_beat(6 + i, 1'b1);
    write_beat(70, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("trunc_drop", drop_count, 3);
    chk("trunc_free", free_words, 256);
    chk("trunc_valid", pkt_valid, 1'b0);
    chk("trunc_wr_addr", wr_addr, 6);

    // reset in the middle of a packet
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    write_beat(6, 1'b1);
    write_beat(7, 1'b1);
    @(negedge clk);
    n_rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mrst_free", free_words, 256);
    chk("mrst_drop", drop_count, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_mem_wen", mem_wen, 1'b0);
    chk("mrst_valid", pkt_valid, 1'b0);
    chk("mrst_base", pkt_base, 0);
    chk("mrst_len", pkt_len, 0);
    chk("mrst_overflow", overflow, 1'b0);
    n_rst = 1'b1;
    idle();

    // release while empty is ignored
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("empty_rel_free", free_words, 256);
    chk("empty_rel_valid", pkt_valid, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
